// File: rtl/nanorisc_pkg.sv
// Shared nanorisc definitions: instruction opcodes, opcode field placement
// and the program-loader state type used by the control unit and the loader.
package nanorisc_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    OP_SUM  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_LWI  = 3'b011,
    OP_SWI  = 3'b100,
    OP_BNE  = 3'b101,
    OP_HALT = 3'b110,
    OP_SEND = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_e;

  // The opcode sits in the top OPC_W bits of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of8(input logic [7:0] instr);
    return instr[7 -: OPC_W];
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Streams a program from an upstream valid/ready source into instruction
// memory, releasing the CPU once a halt word lands.
module instr_loader
  import nanorisc_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_run,
  output logic               busy,
  output logic               overflow,
  output logic [ADDR_W:0]    word_count,
  output loader_state_e      state_dbg
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'((1 << ADDR_W) - 1);

  loader_state_e state;
  logic          xfer;
  logic          is_halt;

  // Handshake: a word moves when in_valid && in_ready on a rising edge.
  // in_ready depends only on state, never on in_valid; the source must hold
  // in_data stable while in_valid is high and in_ready is low.
  assign in_ready  = (state == ST_LOAD);
  assign busy      = (state == ST_LOAD);
  assign xfer      = in_valid && in_ready;
  assign is_halt   = (opcode_e'(in_data[INSTR_W-1 -: OPC_W]) == OP_HALT);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_run    <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LOAD;
            cpu_run    <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            mem_we     <= 1'b1;
            mem_addr   <= word_count[ADDR_W-1:0];
            mem_wdata  <= in_data;
            word_count <= word_count + 1'b1;
            // Halt takes priority so a halt in the last slot still completes.
            if (is_halt) begin
              state   <= ST_DONE;
              cpu_run <= 1'b1;
            end else if (word_count == LAST_ADDR) begin
              state    <= ST_ERROR;
              overflow <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: ADDR_W, default 5, instruction-memory address width (depth 2^ADDR_W words).
REQ-002 Parameter: INSTR_W, default 8, instruction width; opcode is bits [INSTR_W-1:INSTR_W-3].
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  pulse; begins a new program load at address 0.
REQ-006 Port: in_valid  input  1  upstream instruction word valid.
REQ-007 Port: in_data  input  INSTR_W  upstream instruction word.
REQ-008 Port: in_ready  output  1  loader accepts a word this cycle.
REQ-009 Port: mem_we  output  1  instruction-memory write strobe.
REQ-010 Port: mem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 Port: mem_wdata  output  INSTR_W  instruction-memory write data.
REQ-012 Port: cpu_run  output  1  releases CPU PC/fetch; high only when a complete program is loaded.
REQ-013 Port: busy  output  1  high while in LOAD.
REQ-014 Port: overflow  output  1  sticky; memory filled without a halt word.
REQ-015 Port: word_count  output  ADDR_W+1  number of words written in current/last load.

Function
REQ-016 States: IDLE, LOAD, DONE, ERROR; encoding in shared package.
REQ-017 IDLE: start=1 -> LOAD, word_count cleared to 0, overflow cleared.
REQ-018 in_ready SHALL equal 1 only in LOAD; transfer occurs when in_valid & in_ready.
REQ-019 Transfer latency: on the edge after a transfer, mem_we=1 for exactly one cycle, mem_addr=word_count value at transfer, mem_wdata=transferred word.
REQ-020 word_count SHALL increment by 1 on every transfer, registered alongside the write.
REQ-021 Transfer whose opcode is halt (3'b110): word written, state -> DONE on same edge.
REQ-022 Transfer of non-halt word at address 2^ADDR_W-1 (memory full): word written, state -> ERROR, overflow=1.
REQ-023 Halt word at address 2^ADDR_W-1: DONE, not ERROR; overflow stays 0.
REQ-024 DONE: cpu_run=1 held; in_ready=0.
REQ-025 ERROR: cpu_run=0, in_ready=0, overflow held 1.
REQ-026 start in LOAD SHALL be ignored; start in DONE or ERROR -> LOAD, cpu_run drops to 0 on the same edge, counters/overflow cleared.
REQ-027 in_valid while not in LOAD SHALL be ignored; no memory write.
REQ-028 Opcodes other than halt (sum, sub, mul, lwi, swi, bne, send) SHALL be written unmodified, no filtering.
REQ-029 busy SHALL equal (state==LOAD); all outputs registered except in_ready and busy (decoded from state).

Reset
REQ-030 reset SHALL win over start and any transfer in the same cycle.
REQ-031 Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, overflow=0, word_count=0.
REQ-032 Reset mid-LOAD SHALL abort the load, suppress any pending mem_we on the next cycle, leave cpu_run=0.

Structure
REQ-033 Shared package nanorisc_pkg SHALL hold opcode constants (OP_SUM=000, OP_SUB=001, OP_MUL=010, OP_LWI=011, OP_SWI=100, OP_BNE=101, OP_HALT=110, OP_SEND=111), opcode field position, loader state type.
REQ-034 Control unit and loader SHALL both take opcode values from nanorisc_pkg.
REQ-035 Single module; no sub-module (counter and FSM are inline).

Verification
REQ-036 Load 3 words 0x05,0x2A,0xC0 back-to-back after start -> writes addr 0,1,2 with those data, DONE, cpu_run=1, word_count=3.
REQ-037 in_valid toggling every other cycle with 2 words then halt -> exactly 3 mem_we pulses, addresses contiguous, no duplicate writes.
REQ-038 ADDR_W=5, 32 non-halt words (0x00) -> last write addr 31, ERROR, overflow=1, cpu_run=0, word_count=32; 33rd word not accepted (in_ready=0).
REQ-039 31 non-halt words then 0xC0 at addr 31 -> DONE, overflow=0, word_count=32.
REQ-040 reset asserted the cycle after 2nd transfer -> no mem_we following, all outputs at reset values; start then reloads from addr 0.
REQ-041 start during LOAD ignored; start in DONE -> cpu_run=0 next cycle, word_count=0, new load at addr 0.
